// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;
    localparam int DEPTH_DEF  = 256;
    // Counter must reach DEPTH itself, hence the extra bit.
    localparam int CNT_W      = $clog2(DEPTH_DEF) + 1;
    // Word index to byte address.
    localparam int ADDR_SHIFT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Word stream in and instruction-memory write port out.
interface imem_loader_if #(parameter int N = 32);
    logic         s_valid;
    logic [N-1:0] s_data;
    logic         s_ready;
    logic         WE;
    logic [N-1:0] A;
    logic [N-1:0] WD;

    // Host / memory side.
    modport master (output s_valid, s_data, input s_ready, WE, A, WD);
    // Loader side.
    modport slave  (input s_valid, s_data, output s_ready, WE, A, WD);
endinterface

// File: rtl/imem_loader_load_counter.sv
// Word counter with latched session length and terminal-count flag.
module load_counter
    import imem_loader_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] len,
    output logic [W-1:0] cnt,
    output logic         tc
);
    logic [W-1:0] len_q;

    // Clear also captures the session length; increment once per transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (clr) begin
            cnt   <= '0;
            len_q <= len;
        end else if (inc) begin
            cnt   <= cnt + W'(1);
        end
    end

    // High while the current word is the last of the session.
    assign tc = (cnt == len_q - W'(1));
endmodule

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory, holding the core in
// reset until the final word has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [$clog2(DEPTH):0] len,
    imem_loader_if.slave         bus,
    output logic                 core_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state, state_n;
    logic          clr, inc, tc, xfer, len_ok;
    logic [CW-1:0] cnt;

    assign len_ok      = (len != '0) && (len <= CW'(DEPTH));
    assign bus.s_ready = (state == LOAD);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign xfer        = bus.s_valid & bus.s_ready;

    load_counter #(.W(CW)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (inc),
        .len (len),
        .cnt (cnt),
        .tc  (tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and counter control.
    always_comb begin
        state_n = state;
        clr     = 1'b0;
        inc     = 1'b0;
        case (state)
            IDLE: if (start && len_ok) begin
                state_n = LOAD;
                clr     = 1'b1;
            end
            LOAD: if (xfer) begin
                inc = 1'b1;
                if (tc) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered write port, core reset and sticky error; A/WD hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.WE   <= 1'b0;
            bus.A    <= '0;
            bus.WD   <= '0;
            core_rst <= 1'b1;
            err      <= 1'b0;
        end else begin
            bus.WE <= xfer;
            if (xfer) begin
                bus.A  <= N'(cnt) << ADDR_SHIFT;
                bus.WD <= bus.s_data;
            end
            if (state == IDLE && start) begin
                if (len_ok) begin
                    err      <= 1'b0;
                    core_rst <= 1'b1;
                end else begin
                    err      <= 1'b1;
                end
            end
            // Release only after the last write has been presented.
            if (state == DONE) core_rst <= 1'b0;
        end
    end
endmodule
